operand_fetch: RTL and testbench

- Decode-to-execute stage that sits between the instruction decoder and the ALU/EX stage, directly downstream of the register file.
- Drives the register-file read addresses and takes the combinational read data.
- Applies a writeback bypass and registers operands plus control into a one-entry pipeline register with a valid/ready handshake.
- Supports stall, flush, and in-place refresh of held operands when writeback updates a source register.

---
 rtl/opfetch_pkg.sv | 35 +++
 rtl/operand_fetch_if.sv | 75 +++++++
 rtl/opfetch_scoreboard.sv | 66 ++++++
 rtl/operand_fetch.sv | 128 ++++++++++++
 tb/tb_operand_fetch.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/opfetch_pkg.sv
// ============================================================================
// opfetch_pkg : shared register-index types, EX payload struct, bypass helper
// Revision    : 1.0
// ============================================================================
`default_nettype none

package opfetch_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;
   localparam int OPF_XLEN   = 32;
   localparam int OPF_CTRL_W = 16;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Payload handed to EX alongside the two operand values.
   typedef struct packed {
      reg_addr_t             rd;
      logic                  regwrite;
      reg_addr_t             rs1;
      reg_addr_t             rs2;
      logic [OPF_XLEN-1:0]   imm;
      logic [OPF_XLEN-1:0]   pc;
      logic [OPF_CTRL_W-1:0] ctrl;
   } ex_payload_t;

   // True when the writeback port is updating a real (nonzero) source register.
   function automatic logic wb_hits(input logic we, input reg_addr_t wreg, input reg_addr_t src);
      return we && (wreg == src) && (src != REG_ZERO);
   endfunction

endpackage

`default_nettype wire

// File: rtl/operand_fetch_if.sv
// ============================================================================
// operand_fetch_if : decode, register-file, writeback and EX signals of the stage
// Revision         : 1.0
// ============================================================================
`default_nettype none

interface operand_fetch_if
   import opfetch_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
) ();

   logic              in_valid;
   logic              in_ready;
   reg_addr_t         in_rs1;
   reg_addr_t         in_rs2;
   reg_addr_t         in_rd;
   logic              in_regwrite;
   logic [XLEN-1:0]   in_imm;
   logic [XLEN-1:0]   in_pc;
   logic [CTRL_W-1:0] in_ctrl;

   reg_addr_t         rf_read_reg1;
   reg_addr_t         rf_read_reg2;
   logic [XLEN-1:0]   rf_read_data1;
   logic [XLEN-1:0]   rf_read_data2;

   logic              wb_regwrite;
   reg_addr_t         wb_write_reg;
   logic [XLEN-1:0]   wb_write_data;

   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_rs1_data;
   logic [XLEN-1:0]   out_rs2_data;
   reg_addr_t         out_rs1;
   reg_addr_t         out_rs2;
   reg_addr_t         out_rd;
   logic              out_regwrite;
   logic [XLEN-1:0]   out_imm;
   logic [XLEN-1:0]   out_pc;
   logic [CTRL_W-1:0] out_ctrl;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_regwrite, in_imm, in_pc, in_ctrl,
      output in_ready,
      output rf_read_reg1, rf_read_reg2,
      input  rf_read_data1, rf_read_data2,
      input  wb_regwrite, wb_write_reg, wb_write_data,
      input  flush,
      output out_valid,
      input  out_ready,
      output out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd, out_regwrite,
      output out_imm, out_pc, out_ctrl
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_regwrite, in_imm, in_pc, in_ctrl,
      input  in_ready,
      input  rf_read_reg1, rf_read_reg2,
      output rf_read_data1, rf_read_data2,
      output wb_regwrite, wb_write_reg, wb_write_data,
      output flush,
      input  out_valid,
      output out_ready,
      input  out_rs1_data, out_rs2_data, out_rs1, out_rs2, out_rd, out_regwrite,
      input  out_imm, out_pc, out_ctrl
   );

endinterface

`default_nettype wire

// File: rtl/opfetch_scoreboard.sv
// ============================================================================
// opfetch_scoreboard : pending-write bit vector and source-hazard stall lookup
// Used only when OPFETCH_SCOREBOARD_EN is defined.       Revision : 1.0
// ============================================================================
`default_nettype none

module opfetch_scoreboard
   import opfetch_pkg::*;
(
   input  wire       clk,
   input  wire       reset_n,
   input  wire       i_flush,
   input  wire       i_set_en,
   input  reg_addr_t i_set_reg,
   input  wire       i_clr_en,
   input  reg_addr_t i_clr_reg,
   input  wire       i_in_valid,
   input  reg_addr_t i_in_rs1,
   input  reg_addr_t i_in_rs2,
   input  wire       i_held_wr,
   input  reg_addr_t i_held_rd,
   output logic      o_stall
);

   logic [NUM_REGS-1:1] r_pending;
   logic [NUM_REGS-1:0] w_pending;
   logic                w_blk1;
   logic                w_blk2;

   assign w_pending = {r_pending, 1'b0};

   // Set is checked before clear so a same-cycle set/clear leaves the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pending <= '0;
      end else if (i_flush) begin
         r_pending <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (i_set_en && (i_set_reg == reg_addr_t'(i))) begin
               r_pending[i] <= 1'b1;
            end else if (i_clr_en && (i_clr_reg == reg_addr_t'(i))) begin
               r_pending[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_blk1 = 1'b0;
      w_blk2 = 1'b0;
      if (i_in_rs1 != REG_ZERO) begin
         w_blk1 = (w_pending[i_in_rs1] && !wb_hits(i_clr_en, i_clr_reg, i_in_rs1))
                  || (i_held_wr && (i_held_rd == i_in_rs1));
      end
      if (i_in_rs2 != REG_ZERO) begin
         w_blk2 = (w_pending[i_in_rs2] && !wb_hits(i_clr_en, i_clr_reg, i_in_rs2))
                  || (i_held_wr && (i_held_rd == i_in_rs2));
      end
   end

   assign o_stall = i_in_valid && (w_blk1 || w_blk2);

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch : register-file read, writeback bypass, one-entry EX register
// Optional hazard scoreboard: OPFETCH_SCOREBOARD_EN.      Revision : 1.0
// ============================================================================
`default_nettype none

module operand_fetch
   import opfetch_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int CTRL_W = 16
) (
   input  wire             clk,
   input  wire             reset_n,
   operand_fetch_if.slave  bus
);

   logic              w_stall;
   logic              w_capture;
   logic [XLEN-1:0]   w_op1;
   logic [XLEN-1:0]   w_op2;

   logic              r_valid;
   reg_addr_t         r_rs1;
   reg_addr_t         r_rs2;
   reg_addr_t         r_rd;
   logic              r_regwrite;
   logic [XLEN-1:0]   r_rs1_data;
   logic [XLEN-1:0]   r_rs2_data;
   logic [XLEN-1:0]   r_imm;
   logic [XLEN-1:0]   r_pc;
   logic [CTRL_W-1:0] r_ctrl;

   assign bus.rf_read_reg1 = bus.in_rs1;
   assign bus.rf_read_reg2 = bus.in_rs2;

   always_comb begin
      w_op1 = bus.rf_read_data1;
      w_op2 = bus.rf_read_data2;
      if (bus.in_rs1 == REG_ZERO) begin
         w_op1 = '0;
      end else if (wb_hits(bus.wb_regwrite, bus.wb_write_reg, bus.in_rs1)) begin
         w_op1 = bus.wb_write_data;
      end
      if (bus.in_rs2 == REG_ZERO) begin
         w_op2 = '0;
      end else if (wb_hits(bus.wb_regwrite, bus.wb_write_reg, bus.in_rs2)) begin
         w_op2 = bus.wb_write_data;
      end
   end

`ifdef OPFETCH_SCOREBOARD_EN
   opfetch_scoreboard u_scoreboard (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_flush    (bus.flush),
      .i_set_en   (r_valid && bus.out_ready && r_regwrite),
      .i_set_reg  (r_rd),
      .i_clr_en   (bus.wb_regwrite),
      .i_clr_reg  (bus.wb_write_reg),
      .i_in_valid (bus.in_valid),
      .i_in_rs1   (bus.in_rs1),
      .i_in_rs2   (bus.in_rs2),
      .i_held_wr  (r_valid && r_regwrite),
      .i_held_rd  (r_rd),
      .o_stall    (w_stall)
   );
`else
   assign w_stall = 1'b0;
`endif

   assign bus.in_ready = (!r_valid || bus.out_ready) && !w_stall;
   assign w_capture    = bus.in_valid && bus.in_ready;

   // Flush outranks capture; when nothing is captured the held operands track
   // writeback so a stalled instruction never carries a stale value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid    <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_ctrl     <= '0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_valid    <= 1'b1;
         r_rs1      <= bus.in_rs1;
         r_rs2      <= bus.in_rs2;
         r_rd       <= bus.in_rd;
         r_regwrite <= bus.in_regwrite;
         r_rs1_data <= w_op1;
         r_rs2_data <= w_op2;
         r_imm      <= bus.in_imm;
         r_pc       <= bus.in_pc;
         r_ctrl     <= bus.in_ctrl;
      end else begin
         if (bus.out_ready) begin
            r_valid <= 1'b0;
         end
         if (wb_hits(bus.wb_regwrite, bus.wb_write_reg, r_rs1)) begin
            r_rs1_data <= bus.wb_write_data;
         end
         if (wb_hits(bus.wb_regwrite, bus.wb_write_reg, r_rs2)) begin
            r_rs2_data <= bus.wb_write_data;
         end
      end
   end

   assign bus.out_valid    = r_valid;
   assign bus.out_rs1      = r_rs1;
   assign bus.out_rs2      = r_rs2;
   assign bus.out_rd       = r_rd;
   assign bus.out_regwrite = r_regwrite;
   assign bus.out_rs1_data = r_rs1_data;
   assign bus.out_rs2_data = r_rs2_data;
   assign bus.out_imm      = r_imm;
   assign bus.out_pc       = r_pc;
   assign bus.out_ctrl     = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// tb_operand_fetch : directed scenarios plus randomized run against a queue and
// register-file model. Scoreboard scenario compiled with OPFETCH_SCOREBOARD_EN.
// ============================================================================
`default_nettype none

module tb_operand_fetch;
   import opfetch_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] rf [32];

   operand_fetch_if #(.XLEN(32), .CTRL_W(16)) bus ();

   operand_fetch #(.XLEN(32), .CTRL_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Architectural register file: a register always holds its latest write.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h9E37_79B1;
      end else if (bus.wb_regwrite && bus.wb_write_reg != 5'd0) begin
         rf[bus.wb_write_reg] <= bus.wb_write_data;
      end
   end

   always_comb begin
      bus.rf_read_data1 = (bus.rf_read_reg1 == 5'd0) ? 32'd0 : rf[bus.rf_read_reg1];
      bus.rf_read_data2 = (bus.rf_read_reg2 == 5'd0) ? 32'd0 : rf[bus.rf_read_reg2];
   end

   function automatic ex_payload_t get_out();
      ex_payload_t p;
      p.rd = bus.out_rd; p.regwrite = bus.out_regwrite;
      p.rs1 = bus.out_rs1; p.rs2 = bus.out_rs2;
      p.imm = bus.out_imm; p.pc = bus.out_pc; p.ctrl = bus.out_ctrl;
      return p;
   endfunction

   function automatic ex_payload_t mk(input logic [31:0] pc, input reg_addr_t rs1,
                                      input reg_addr_t rs2, input reg_addr_t rd, input logic rw);
      ex_payload_t p;
      p.rd = rd; p.regwrite = rw; p.rs1 = rs1; p.rs2 = rs2;
      p.imm = pc ^ 32'h5A5A_0000; p.pc = pc; p.ctrl = pc[15:0] ^ 16'h0F0F;
      return p;
   endfunction

   task automatic drive_idle();
      bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
      bus.in_regwrite = 1'b0; bus.in_imm = '0; bus.in_pc = '0; bus.in_ctrl = '0;
      bus.wb_regwrite = 1'b0; bus.wb_write_reg = '0; bus.wb_write_data = '0;
      bus.flush = 1'b0; bus.out_ready = 1'b1;
   endtask

   task automatic drive_instr(input ex_payload_t p);
      bus.in_valid = 1'b1; bus.in_rs1 = p.rs1; bus.in_rs2 = p.rs2; bus.in_rd = p.rd;
      bus.in_regwrite = p.regwrite; bus.in_imm = p.imm; bus.in_pc = p.pc; bus.in_ctrl = p.ctrl;
   endtask

   task automatic test_reset();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      n_checks++; if (get_out() !== '0) begin n_errors++; $display("FAIL reset_payload got=%h exp=0", get_out()); end
      n_checks++; if ({bus.out_rs1_data, bus.out_rs2_data} !== 64'd0) begin n_errors++; $display("FAIL reset_operands got=%h exp=0", {bus.out_rs1_data, bus.out_rs2_data}); end
      drive_instr(mk(32'h40, 5'd1, 5'd2, 5'd3, 1'b0));
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      drive_idle(); bus.out_ready = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL reset_pre_valid got=%b exp=1", bus.out_valid); end
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_async_valid got=%b exp=0", bus.out_valid); end
      n_checks++; if (bus.out_pc !== 32'd0) begin n_errors++; $display("FAIL reset_async_pc got=%h exp=0", bus.out_pc); end
      @(posedge clk); #1 reset_n = 1'b1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready); end
      drive_idle();
   endtask

   task automatic test_bypass();
      bus.wb_regwrite = 1'b1; bus.wb_write_reg = 5'd5; bus.wb_write_data = 32'h11;
      @(posedge clk); #1;
      bus.wb_write_data = 32'hAA;
      drive_instr(mk(32'h200, 5'd5, 5'd0, 5'd9, 1'b0));
      @(negedge clk);
      n_checks++; if (bus.rf_read_reg1 !== 5'd5) begin n_errors++; $display("FAIL bypass_rf_addr got=%0d exp=5", bus.rf_read_reg1); end
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL bypass_valid got=%b exp=1", bus.out_valid); end
      n_checks++; if (bus.out_rs1_data !== 32'hAA) begin n_errors++; $display("FAIL bypass_rs1 got=%h exp=aa", bus.out_rs1_data); end
      n_checks++; if (bus.out_rs2_data !== 32'h0) begin n_errors++; $display("FAIL bypass_x0_rs2 got=%h exp=0", bus.out_rs2_data); end
      bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'hDEAD_BEEF;
      drive_instr(mk(32'h204, 5'd0, 5'd5, 5'd9, 1'b0));
      @(posedge clk); #1;
      n_checks++; if (bus.out_rs1_data !== 32'h0) begin n_errors++; $display("FAIL bypass_wb_x0 got=%h exp=0", bus.out_rs1_data); end
      n_checks++; if (bus.out_rs2_data !== 32'hAA) begin n_errors++; $display("FAIL bypass_rf_rs2 got=%h exp=aa", bus.out_rs2_data); end
      n_checks++; if (bus.out_pc !== 32'h204) begin n_errors++; $display("FAIL bypass_pc got=%h exp=204", bus.out_pc); end
      drive_idle();
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL bypass_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_stall_refresh();
      drive_instr(mk(32'h300, 5'd1, 5'd7, 5'd2, 1'b0));
      @(posedge clk); #1;
      drive_instr(mk(32'h304, 5'd0, 5'd7, 5'd2, 1'b0));
      bus.out_ready = 1'b0;
      bus.wb_regwrite = 1'b1; bus.wb_write_reg = 5'd7; bus.wb_write_data = 32'h1234;
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_valid got=%b exp=1", bus.out_valid); end
      n_checks++; if (bus.out_rs2_data !== 32'h1234) begin n_errors++; $display("FAIL stall_refresh got=%h exp=1234", bus.out_rs2_data); end
      n_checks++; if (bus.out_pc !== 32'h300) begin n_errors++; $display("FAIL stall_held_pc got=%h exp=300", bus.out_pc); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready2 got=%b exp=0", bus.in_ready); end
      drive_idle();
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         drive_instr(mk(32'h400 + 32'(4 * k), 5'(k + 1), 5'(k + 2), 5'd4, 1'b0));
         @(posedge clk); #1;
         n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, bus.out_valid); end
         n_checks++; if (bus.out_pc !== 32'h400 + 32'(4 * k)) begin n_errors++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, bus.out_pc, 32'h400 + 32'(4 * k)); end
      end
      drive_idle();
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_flush();
      drive_instr(mk(32'h500, 5'd1, 5'd2, 5'd3, 1'b0));
      @(posedge clk); #1;
      drive_instr(mk(32'h504, 5'd1, 5'd2, 5'd3, 1'b0));
      bus.out_ready = 1'b0; bus.flush = 1'b1;
      @(posedge clk); #1;
      drive_idle();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_no_ghost got=%b exp=0", bus.out_valid); end
   endtask

`ifdef OPFETCH_SCOREBOARD_EN
   task automatic test_scoreboard();
      drive_instr(mk(32'h600, 5'd0, 5'd0, 5'd3, 1'b1));
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL sb_issue got=%b exp=1", bus.out_valid); end
      drive_instr(mk(32'h604, 5'd3, 5'd0, 5'd0, 1'b0));
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL sb_held_stall got=%b exp=0", bus.in_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL sb_drained got=%b exp=0", bus.out_valid); end
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL sb_pending_stall got=%b exp=0", bus.in_ready); end
      @(posedge clk); #1;
      bus.wb_regwrite = 1'b1; bus.wb_write_reg = 5'd3; bus.wb_write_data = 32'h3333;
      @(negedge clk);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++; $display("FAIL sb_release got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h604) begin n_errors++; $display("FAIL sb_accept got=%b/%h exp=1/604", bus.out_valid, bus.out_pc); end
      n_checks++; if (bus.out_rs1_data !== 32'h3333) begin n_errors++; $display("FAIL sb_bypass got=%h exp=3333", bus.out_rs1_data); end
      drive_idle();
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_random(input int n);
      ex_payload_t q[$];
      ex_payload_t cur;
      logic        exp_ready;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         cur.rs1 = 5'($urandom_range(0, 7));
         cur.rs2 = 5'($urandom_range(0, 7));
         cur.rd  = 5'($urandom_range(0, 7));
`ifdef OPFETCH_SCOREBOARD_EN
         cur.regwrite = 1'b0;
`else
         cur.regwrite = 1'($urandom);
`endif
         cur.imm = $urandom; cur.pc = $urandom; cur.ctrl = 16'($urandom);
         drive_instr(cur);
         bus.in_valid      = ($urandom_range(0, 3) != 0);
         bus.out_ready     = ($urandom_range(0, 2) != 0);
         bus.flush         = ($urandom_range(0, 11) == 0);
         bus.wb_regwrite   = 1'($urandom);
         bus.wb_write_reg  = 5'($urandom_range(0, 7));
         bus.wb_write_data = $urandom;
         @(negedge clk);
         exp_ready = (q.size() == 0) || bus.out_ready;
         n_checks++; if (bus.out_valid !== (q.size() != 0)) begin n_errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, q.size() != 0); end
         n_checks++; if (bus.in_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_ready); end
         if (q.size() != 0) begin
            n_checks++; if (get_out() !== q[0]) begin n_errors++; $display("FAIL rnd_payload c=%0d got=%h exp=%h", c, get_out(), q[0]); end
            n_checks++; if (bus.out_rs1_data !== rf[q[0].rs1]) begin n_errors++; $display("FAIL rnd_rs1_data c=%0d got=%h exp=%h", c, bus.out_rs1_data, rf[q[0].rs1]); end
            n_checks++; if (bus.out_rs2_data !== rf[q[0].rs2]) begin n_errors++; $display("FAIL rnd_rs2_data c=%0d got=%h exp=%h", c, bus.out_rs2_data, rf[q[0].rs2]); end
         end
         if (bus.flush) begin
            q.delete();
         end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && exp_ready) q.push_back(cur);
         end
      end
      @(posedge clk); #1;
      drive_idle();
   endtask

   initial begin
      reset_n = 1'b0;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      test_reset();
      test_bypass();
      test_stall_refresh();
      test_back_to_back();
      test_flush();
`ifdef OPFETCH_SCOREBOARD_EN
      test_scoreboard();
`endif
      @(posedge clk); #1;
      test_random(400);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
